// File: rtl/mm_job_dispatcher_if.sv
// Job intake channel between the config side and mm_job_dispatcher.
// The config side (master) offers a job; the dispatcher (slave) accepts it on valid & ready.
interface mm_job_dispatcher_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
);
    logic                  job_valid_i;
    logic                  job_ready_o;
    logic [ADDR_WIDTH-1:0] job_a_addr_i;
    logic [ADDR_WIDTH-1:0] job_b_addr_i;
    logic [ADDR_WIDTH-1:0] job_c_addr_i;
    logic [DIM_WIDTH-1:0]  job_m_i;
    logic [DIM_WIDTH-1:0]  job_n_i;
    logic [DIM_WIDTH-1:0]  job_p_i;

    modport master (
        output job_valid_i, job_a_addr_i, job_b_addr_i, job_c_addr_i,
               job_m_i, job_n_i, job_p_i,
        input  job_ready_o
    );

    modport slave (
        input  job_valid_i, job_a_addr_i, job_b_addr_i, job_c_addr_i,
               job_m_i, job_n_i, job_p_i,
        output job_ready_o
    );
endinterface

// File: rtl/mm_job_dispatcher.sv
// Matrix-multiply job dispatcher: queues jobs in a small FIFO, rejects jobs with a zero
// dimension, launches one job at a time on the systolic array, watches for the done edge
// or a watchdog timeout, and counts normal completions.
module mm_job_dispatcher #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DIM_WIDTH      = 16,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mm_job_dispatcher_if.slave      job,
    input  logic                    flush_i,
    output logic                    start_o,
    output logic [ADDR_WIDTH-1:0]   base_addr_a_o,
    output logic [ADDR_WIDTH-1:0]   base_addr_b_o,
    output logic [ADDR_WIDTH-1:0]   base_addr_c_o,
    output logic [DIM_WIDTH-1:0]    m_o,
    output logic [DIM_WIDTH-1:0]    n_o,
    output logic [DIM_WIDTH-1:0]    p_o,
    input  logic                    operation_done_i,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  queue_level_o,
    output logic                    job_done_o,
    output logic                    job_error_o,
    output logic [15:0]             jobs_completed_o
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] c;
        logic [DIM_WIDTH-1:0]  m;
        logic [DIM_WIDTH-1:0]  n;
        logic [DIM_WIDTH-1:0]  p;
    } job_t;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    job_t                  r_mem [DEPTH];
    job_t                  r_head;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;
    state_t                r_state;
    logic [31:0]           r_run_cnt;
    logic                  r_done_d;
    logic                  r_start;
    logic                  r_job_done;
    logic                  r_job_error;
    logic [15:0]           r_completed;
    logic [ADDR_WIDTH-1:0] r_base_a;
    logic [ADDR_WIDTH-1:0] r_base_b;
    logic [ADDR_WIDTH-1:0] r_base_c;
    logic [DIM_WIDTH-1:0]  r_m;
    logic [DIM_WIDTH-1:0]  r_n;
    logic [DIM_WIDTH-1:0]  r_p;

    job_t                  w_in;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_zero_dim;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_done_rise;
    logic                  w_timeout;

    assign w_in        = {job.job_a_addr_i, job.job_b_addr_i, job.job_c_addr_i,
                          job.job_m_i, job.job_n_i, job.job_p_i};
    assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    // Flush blocks intake so a job offered in the flush cycle cannot survive it.
    assign w_ready     = ~w_full & ~flush_i;
    assign w_accept    = job.job_valid_i & w_ready;
    assign w_zero_dim  = (job.job_m_i == '0) | (job.job_n_i == '0) | (job.job_p_i == '0);
    assign w_push      = w_accept & ~w_zero_dim;
    // No pop during flush: everything still queued at that edge is discarded.
    assign w_pop       = (r_state == S_IDLE) & ~w_empty & ~flush_i;
    assign w_done_rise = operation_done_i & ~r_done_d;
    // r_run_cnt holds completed RUN cycles before this edge; this edge ends cycle r_run_cnt+1.
    assign w_timeout   = (TMO != 32'd0) && ((r_run_cnt + 32'd1) == TMO);

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    // Capture the popped entry; it is driven onto the array outputs in LAUNCH.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_head <= r_mem[r_rptr];
        end
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    // Delayed done for edge detection, sampled in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_d <= 1'b0;
        end else begin
            r_done_d <= operation_done_i;
        end
    end

    // Launch FSM with registered start, array operands, status pulses and completion count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_run_cnt   <= '0;
            r_start     <= 1'b0;
            r_job_done  <= 1'b0;
            r_job_error <= 1'b0;
            r_completed <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_base_c    <= '0;
            r_m         <= '0;
            r_n         <= '0;
            r_p         <= '0;
        end else begin
            r_start     <= 1'b0;
            r_job_done  <= 1'b0;
            r_job_error <= w_accept & w_zero_dim;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_base_a  <= r_head.a;
                    r_base_b  <= r_head.b;
                    r_base_c  <= r_head.c;
                    r_m       <= r_head.m;
                    r_n       <= r_head.n;
                    r_p       <= r_head.p;
                    r_start   <= 1'b1;
                    r_run_cnt <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_done_rise) begin
                        r_state     <= S_IDLE;
                        r_job_done  <= 1'b1;
                        r_completed <= r_completed + 16'd1;
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_job_error <= 1'b1;
                    end else if (r_run_cnt != '1) begin
                        r_run_cnt <= r_run_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign job.job_ready_o   = w_ready;
    assign start_o           = r_start;
    assign base_addr_a_o     = r_base_a;
    assign base_addr_b_o     = r_base_b;
    assign base_addr_c_o     = r_base_c;
    assign m_o               = r_m;
    assign n_o               = r_n;
    assign p_o               = r_p;
    assign busy_o            = (r_state != S_IDLE);
    assign queue_level_o     = r_count;
    assign job_done_o        = r_job_done;
    assign job_error_o       = r_job_error;
    assign jobs_completed_o  = r_completed;
endmodule
